// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [1:0] WB_NONE  = 2'b00;

  // A load into $zero never creates a real dependency.
  function automatic logic load_use_hazard(input logic       ex_mem_read,
                                           input logic [4:0] ex_rt,
                                           input logic [4:0] id_rs,
                                           input logic [4:0] id_rt);
    return ex_mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, data-memory waits.
// Define PIPE_PERF_CNT_EN to add saturating performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branchTaken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic             memwb_bubble,
  output logic             dmem_timeout,
  output logic [1:0]       ctrl_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] memwait_cycles
`endif
);

  // One spare count so the incremented value never wraps before the compare.
  localparam int unsigned      WaitW      = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  ctrl_state_e      state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [WaitW-1:0] wait_inc;
  logic             freeze;
  logic             timeout_flag;
  logic             branch_flush;
  logic             lu_stall;
  logic             memwait_inc;

  assign wait_inc = wait_cnt_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    freeze       = 1'b0;
    timeout_flag = 1'b0;
    branch_flush = 1'b0;
    lu_stall     = 1'b0;
    memwait_inc  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WaitW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze      = 1'b1;
          memwait_inc = 1'b1;
          wait_cnt_d  = wait_inc;
          if (wait_inc >= TimeoutVal) begin
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        freeze       = 1'b1;
        timeout_flag = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // A branch held in EX during a freeze takes effect on the release cycle.
    if (!freeze) begin
      if (ex_branchTaken) begin
        branch_flush = 1'b1;
      end else if (load_use_hazard(ex_memRead, ex_rt, id_rs, id_rt)) begin
        lu_stall = 1'b1;
      end
    end

    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    pipe_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    dmem_timeout = timeout_flag;
    ctrl_state   = state_q;

    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      pipe_en      = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      pipe_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      dmem_timeout = 1'b0;
      ctrl_state   = RUN;
      branch_flush = 1'b0;
      lu_stall     = 1'b0;
      memwait_inc  = 1'b0;
      state_d      = RUN;
      wait_cnt_d   = '0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (lu_stall),
    .count(stall_cycles)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (branch_flush),
    .count(flush_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_memwait_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (memwait_inc),
    .count(memwait_cycles)
  );
`endif

endmodule
